// File: rtl/c_buffer_drain.sv
// Drains C result-buffer rows (WORDS x 32-bit) onto a 32-bit valid/ready response stream.
// Optional C_OFFSET_EN: adds a start-sampled signed offset to every word (wraps, no saturation).
module c_buffer_drain #(
  parameter int IDX_W = 16,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IDX_W-1:0]      num_rows,
  output logic [IDX_W-1:0]      C_index,
  input  logic [WORDS*32-1:0]   C_data_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
`ifdef C_OFFSET_EN
  input  logic signed [31:0]    c_offset,
`endif
  output logic [31:0]           rsp_data,
  output logic                  busy,
  output logic                  done
);

  localparam int DATA_W = 32;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         row, row_inc, num_rows_q;
  logic [WORD_W-1:0]        word;
  logic [WORDS*DATA_W-1:0]  row_buf_p1;
  logic [DATA_W-1:0]        lane_p1;
  logic                     done_q;
  logic                     accept;
  logic                     last_hs;

`ifdef C_OFFSET_EN
  logic signed [DATA_W-1:0] offset_q;

  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] s;
    s = $signed(a) + b;
    return s;
  endfunction
`endif

  // done is registered one cycle behind the DONE state; busy spans both cycles
  // so a new start cannot land on top of the outgoing done pulse.
  assign accept  = (state == S_IDLE) && start && !done_q;
  assign row_inc = row + 1'b1;
  assign last_hs = (state == S_SEND) && rsp_ready && (word == WORD_W'(WORDS - 1));
  assign lane_p1 = row_buf_p1[word*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      row        <= '0;
      num_rows_q <= '0;
      word       <= '0;
      row_buf_p1 <= '0;
      done_q     <= 1'b0;
`ifdef C_OFFSET_EN
      offset_q   <= '0;
`endif
    end else begin
      state  <= state_nxt;
      done_q <= (state == S_DONE);
      if (accept) begin
        num_rows_q <= num_rows;
        row        <= '0;
`ifdef C_OFFSET_EN
        offset_q   <= c_offset;
`endif
      end
      // p1: buffer read data captured one cycle after the address
      if (state == S_WAIT) begin
        row_buf_p1 <= C_data_in;
        word       <= '0;
      end
      if ((state == S_SEND) && rsp_ready) begin
        if (last_hs) begin
          word <= '0;
          row  <= row_inc;
        end else begin
          word <= word + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (num_rows == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_SEND;
      S_SEND:  if (last_hs) state_nxt = (row_inc == num_rows_q) ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    C_index   = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if ((state == S_FETCH) || (state == S_WAIT) || (state == S_SEND)) C_index = row;
    if (state == S_SEND) begin
      rsp_valid = 1'b1;
`ifdef C_OFFSET_EN
      rsp_data  = add_wrap(lane_p1, offset_q);
`else
      rsp_data  = lane_p1;
`endif
    end
  end

  assign busy = (state != S_IDLE) || done_q;
  assign done = done_q;

endmodule

// File: tb/tb_c_buffer_drain.sv
// Directed bench for c_buffer_drain: basic drain, backpressure, zero rows, reset, start-while-busy,
// and the C_OFFSET_EN offset cases when that macro is defined.
module tb_c_buffer_drain;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   num_rows;
  logic [15:0]   C_index;
  logic [127:0]  C_data_in;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          busy;
  logic          done;
`ifdef C_OFFSET_EN
  logic signed [31:0] c_offset;
`endif

  logic [127:0]  mem [0:15];
  logic [31:0]   got [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            nd;

  c_buffer_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .C_index   (C_index),
    .C_data_in (C_data_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
`ifdef C_OFFSET_EN
    .c_offset  (c_offset),
`endif
    .rsp_data  (rsp_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Buffer model: read data appears one cycle after the address.
  always @(posedge clk) C_data_in <= mem[C_index[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start    = 1'b1;
    num_rows = n;
    tick();
    start    = 1'b0;
  endtask

  // Runs the consumer side until done is seen or the budget expires.
  task automatic run_drain(input int budget, input bit toggle, input int start_at, output int n_done);
    bit          stalled = 1'b0;
    logic [31:0] held    = '0;
    n_done = 0;
    got.delete();
    for (int i = 0; i < budget; i++) begin
      rsp_ready = toggle ? i[0] : 1'b1;
      start     = (i == start_at);
      num_rows  = (i == start_at) ? 16'd9 : num_rows;
      if (stalled) begin
        chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
        chk("stall_data", rsp_data, held);
      end
      if (rsp_valid && rsp_ready) got.push_back(rsp_data);
      stalled = rsp_valid && !rsp_ready;
      held    = rsp_data;
      if (done) begin
        n_done++;
        chk("busy_in_done", {31'b0, busy}, 32'd1);
        tick();
        chk("done_width", {31'b0, done}, 32'd0);
        chk("busy_after_done", {31'b0, busy}, 32'd0);
        break;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic check_words(input string tag, input int n, input int first);
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_word"}, got[i], first + i);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < 16; r++)
      mem[r] = {32'(4*r + 4), 32'(4*r + 3), 32'(4*r + 2), 32'(4*r + 1)};
    rst_n     = 1'b0;
    start     = 1'b0;
    num_rows  = '0;
    rsp_ready = 1'b1;
`ifdef C_OFFSET_EN
    c_offset  = '0;
`endif
    tick();
    tick();
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_index", {16'b0, C_index}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. basic drain with first-valid latency of 3 cycles
    do_start(16'd2);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_index", {16'b0, C_index}, 32'd0);
    chk("t1_valid_t1", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("t1_valid_t2", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("t1_valid_t3", {31'b0, rsp_valid}, 32'd1);
    run_drain(100, 1'b0, -1, nd);
    chk("t1_done", nd, 32'd1);
    check_words("t1", 8, 1);

    // 2. backpressure toggling every cycle
    tick();
    do_start(16'd2);
    run_drain(200, 1'b1, -1, nd);
    chk("t2_done", nd, 32'd1);
    check_words("t2", 8, 1);

    // 3. zero rows: busy two cycles, done in the second
    tick();
    rsp_ready = 1'b1;
    do_start(16'd0);
    chk("t3_busy_t1", {31'b0, busy}, 32'd1);
    chk("t3_done_t1", {31'b0, done}, 32'd0);
    chk("t3_valid_t1", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("t3_busy_t2", {31'b0, busy}, 32'd1);
    chk("t3_done_t2", {31'b0, done}, 32'd1);
    chk("t3_valid_t2", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("t3_busy_t3", {31'b0, busy}, 32'd0);
    chk("t3_done_t3", {31'b0, done}, 32'd0);

    // 4. reset while the second word of a 4-row drain is stalled
    tick();
    rsp_ready = 1'b1;
    do_start(16'd4);
    tick();
    tick();
    tick();
    rsp_ready = 1'b0;
    chk("t4_word2", rsp_data, 32'd2);
    tick();
    chk("t4_word2_held", rsp_data, 32'd2);
    rst_n = 1'b0;
    tick();
    chk("t4_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_done", {31'b0, done}, 32'd0);
    chk("t4_index", {16'b0, C_index}, 32'd0);
    chk("t4_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_done", {31'b0, done}, 32'd0);
    end
    rsp_ready = 1'b1;
    do_start(16'd1);
    run_drain(100, 1'b0, -1, nd);
    chk("t4_restart_done", nd, 32'd1);
    check_words("t4_restart", 4, 1);

    // 5. start while busy is ignored
    tick();
    do_start(16'd3);
    run_drain(200, 1'b0, 4, nd);
    chk("t5_done", nd, 32'd1);
    check_words("t5", 12, 1);
    tick();
    chk("t5_idle", {31'b0, busy}, 32'd0);

`ifdef C_OFFSET_EN
    // 6. offset wraps in 32-bit two's complement
    tick();
    mem[0][31:0] = 32'h0000007F;
    c_offset = -32'sd128;
    do_start(16'd1);
    run_drain(100, 1'b0, -1, nd);
    chk("t6_neg_count", got.size(), 32'd4);
    if (got.size() > 0) chk("t6_neg", got[0], 32'hFFFFFFFF);
    tick();
    mem[0][31:0] = 32'h7FFFFFFF;
    c_offset = 32'sd1;
    do_start(16'd1);
    run_drain(100, 1'b0, -1, nd);
    chk("t6_wrap_count", got.size(), 32'd4);
    if (got.size() > 0) chk("t6_wrap", got[0], 32'h80000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
